// File: rtl/seg_pkg.sv
// Shared segment-code constants and decoder for the countdown display.
// Also holds the state type for the sequential binary-to-BCD converter.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {a,b,c,d,e,f,g}, bit6 = a, 1 = lit
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        if (nib <= 4'd9) begin
            s = SEG_DIGIT[nib];
        end
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side bus of the 7-segment scan driver: load handshake, display
// controls and the multiplexed segment/digit outputs.
interface seg_scan_driver_if #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
);
    logic [W-1:0]      value;
    logic              load;
    logic              busy;
    logic              lzb;
    logic              en_n;
    logic              blink;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;

    modport master (
        output value, load, lzb, en_n, blink,
        input  busy, seg, dig_en
    );

    modport slave (
        input  value, load, lzb, en_n, blink,
        output busy, seg, dig_en
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, W steps.
// done pulses (combinationally) on the final step while bcd carries the result.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          bin,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int unsigned BW = DIGITS * 4;
    localparam int unsigned SW = BW + W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    conv_state_t    state, state_nx;
    logic [SW-1:0]  shreg;
    logic [SW-1:0]  adj;
    logic [SW-1:0]  shifted;
    logic [CW-1:0]  cnt;

    always_comb begin
        adj = shreg;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shreg[W + 4*i +: 4] >= 4'd5) begin
                adj[W + 4*i +: 4] = shreg[W + 4*i +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            CONV_IDLE: if (load) state_nx = CONV_RUN;
            CONV_RUN: begin
                if (cnt == LAST) begin
                    state_nx = CONV_IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = CONV_IDLE;
        endcase
    end

    assign busy = (state == CONV_RUN);
    assign bcd  = shifted[SW-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CONV_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                CONV_IDLE: begin
                    if (load) begin
                        shreg <= SW'(bin);
                        cnt   <= '0;
                    end
                end
                CONV_RUN: begin
                    shreg <= shifted;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment driver: sequential BCD conversion, digit scan,
// leading-zero blanking, global blank and blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic [FW-1:0]          frame;
    logic                   phase_on;
    logic [DIGITS*4-1:0]    disp;
    logic [DIGITS*4-1:0]    conv_bcd;
    logic                   conv_done;

    logic                   presc_tc, idx_wrap, frame_wrap;
    logic [DIGITS-1:0]      zero_up;
    logic                   run_zero;
    logic [3:0]             cur_nib;
    logic                   blank_digit, dark;
    logic [6:0]             seg_nx;
    logic [DIGITS-1:0]      dig_nx;

    bin2bcd_seq #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bus.value),
        .load  (bus.load),
        .busy  (bus.busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign presc_tc   = (presc == PW'(SCAN_DIV - 1));
    assign idx_wrap   = (idx == IW'(DIGITS - 1));
    assign frame_wrap = (frame == FW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            idx      <= '0;
            frame    <= '0;
            phase_on <= 1'b1;
        end else if (presc_tc) begin
            presc <= '0;
            idx   <= idx_wrap ? '0 : idx + 1'b1;
            if (idx_wrap) begin
                frame <= frame_wrap ? '0 : frame + 1'b1;
                if (frame_wrap) phase_on <= ~phase_on;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Whole result lands in one edge so no digit ever shows a half-converted value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp <= '0;
        end else if (conv_done) begin
            disp <= conv_bcd;
        end
    end

    // zero_up[i]: digit i and every higher digit are zero
    always_comb begin
        zero_up  = '0;
        run_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            run_zero = run_zero & (disp[4*(DIGITS-1-k) +: 4] == 4'd0);
            zero_up[DIGITS-1-k] = run_zero;
        end
    end

    always_comb begin
        cur_nib     = disp[{idx, 2'b00} +: 4];
        blank_digit = bus.lzb && (idx != '0) && zero_up[idx];
        dark        = bus.en_n || (bus.blink && !phase_on);
        seg_nx      = (dark || blank_digit) ? SEG_BLANK : seg_decode(cur_nib);
        dig_nx      = dark ? '0 : (DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg    <= SEG_BLANK;
            bus.dig_en <= '0;
        end else begin
            bus.seg    <= seg_nx;
            bus.dig_en <= dig_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a cycle-indexed
// arithmetic model of conversion, scanning, blanking and blink.
module tb_seg_scan_driver;

    localparam int unsigned W         = 8;
    localparam int unsigned DIGITS    = 3;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLINK_DIV = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.W(W), .DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .W         (W),
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] code_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int errors = 0;
    int checks = 0;

    // Model: n is the index of the next rising edge since reset release
    int unsigned n;
    int unsigned m_disp;
    int unsigned m_pend_val;
    int unsigned m_commit_at;
    bit          m_pend;
    bit          m_busy;

    function automatic int unsigned pow10(input int unsigned e);
        int unsigned p = 1;
        for (int unsigned i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input string ph);
        int unsigned       idx, frames, d;
        bit                phase_on, dark, blank;
        logic [6:0]        seg_e;
        logic [DIGITS-1:0] dig_e;
        idx      = ((n - 1) / SCAN_DIV) % DIGITS;
        frames   = (n - 1) / (SCAN_DIV * DIGITS);
        phase_on = ((frames / BLINK_DIV) % 2) == 0;
        dark     = bus.en_n || (bus.blink && !phase_on);
        d        = (m_disp / pow10(idx)) % 10;
        blank    = bus.lzb && (idx != 0) && (m_disp < pow10(idx));
        seg_e    = (dark || blank) ? 7'h00 : code_tab[d];
        dig_e    = dark ? '0 : DIGITS'(1 << idx);
        if (bus.load && !m_busy) begin
            m_pend      = 1'b1;
            m_pend_val  = bus.value;
            m_commit_at = n + W;
        end
        @(posedge clk);
        #1;
        if (m_pend && n == m_commit_at) begin
            m_disp = m_pend_val;
            m_pend = 1'b0;
        end
        m_busy = m_pend;
        n++;
        check({ph, ".seg"},    32'(bus.seg),    32'(seg_e));
        check({ph, ".dig_en"}, 32'(bus.dig_en), 32'(dig_e));
        check({ph, ".busy"},   32'(bus.busy),   32'(m_busy));
    endtask

    task automatic run(input string ph, input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step(ph);
    endtask

    task automatic do_load(input string ph, input logic [W-1:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        step(ph);
        bus.load  = 1'b0;
    endtask

    task automatic do_reset(input string ph);
        rst_n = 1'b0;
        #1;
        check({ph, ".rst_seg"},  32'(bus.seg),    32'd0);
        check({ph, ".rst_dig"},  32'(bus.dig_en), 32'd0);
        check({ph, ".rst_busy"}, 32'(bus.busy),   32'd0);
        n      = 1;
        m_disp = 0;
        m_pend = 1'b0;
        m_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({ph, ".hold_seg"}, 32'(bus.seg),    32'd0);
        check({ph, ".hold_dig"}, 32'(bus.dig_en), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.value = '0;
        bus.load  = 1'b0;
        bus.lzb   = 1'b0;
        bus.en_n  = 1'b0;
        bus.blink = 1'b0;
        #2;
        do_reset("por");
        run("idle", 6);

        do_load("abort", 8'd200);
        run("abort", 2);
        do_reset("abort");
        run("after_abort", 40);

        do_load("v255", 8'd255);
        run("v255", 40);

        bus.lzb = 1'b1;
        do_load("v7_lzb", 8'd7);
        run("v7_lzb", 30);
        bus.lzb = 1'b0;
        run("v7_nolzb", 20);

        bus.lzb = 1'b1;
        do_load("v0_lzb", 8'd0);
        run("v0_lzb", 30);

        do_load("first", 8'd123);
        step("first");
        do_load("drop", 8'd9);
        run("drop", 30);

        bus.en_n = 1'b1;
        run("dark", 15);
        bus.en_n = 1'b0;
        run("undark", 5);

        bus.blink = 1'b1;
        run("blink", 100);
        bus.blink = 1'b0;
        run("unblink", 10);

        for (int unsigned i = 0; i < 1500; i++) begin
            bus.value = W'($urandom_range(0, 255));
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.lzb   = 1'($urandom);
            bus.en_n  = ($urandom_range(0, 15) == 0);
            bus.blink = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_rst");
            end else begin
                step("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
